// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache between the CPU fetch port and instruction memory.
// Hits answer combinationally; misses stall on BUSYWAIT while one 128-bit block refills.
module icache_fetch_responder #(
    parameter int TAG_BITS   = 3,
    parameter int INDEX_BITS = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    PC,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           imem_read,
    output logic [TAG_BITS+INDEX_BITS-1:0] imem_address,
    input  logic [127:0]                   imem_readdata,
    input  logic                           imem_busywait
);

    localparam int NBLK  = 1 << INDEX_BITS;
    localparam int ABITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    state_t                  state;
    logic [NBLK-1:0]         valid;
    logic [TAG_BITS-1:0]     tags [NBLK];
    logic [127:0]            data [NBLK];
    logic [ABITS-1:0]        miss_addr;
    logic                    read_q;

    logic [INDEX_BITS-1:0]   pc_idx;
    logic [TAG_BITS-1:0]     pc_tag;
    logic [ABITS-1:0]        pc_blk;
    logic [INDEX_BITS-1:0]   miss_idx;
    logic [TAG_BITS-1:0]     miss_tag;
    logic                    hit;
    logic                    unused;

    assign pc_idx   = PC[4 +: INDEX_BITS];
    assign pc_tag   = PC[4+INDEX_BITS +: TAG_BITS];
    assign pc_blk   = {pc_tag, pc_idx};
    assign miss_idx = miss_addr[INDEX_BITS-1:0];
    assign miss_tag = miss_addr[ABITS-1:INDEX_BITS];
    assign hit      = valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign unused   = ^{PC[31:4+ABITS], PC[1:0]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            valid     <= '0;
            read_q    <= 1'b0;
            miss_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_addr <= pc_blk;
                        read_q    <= 1'b1;
                        state     <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!imem_busywait) begin
                        read_q <= 1'b0;
                        state  <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid[miss_idx] <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    read_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays hold no reset; the valid bits alone guard them.
    always_ff @(posedge CLK) begin
        if (!RESET && state == UPDATE) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= imem_readdata;
        end
    end

    always_comb begin
        INSTRUCTION  = '0;
        BUSYWAIT     = 1'b0;
        imem_read    = 1'b0;
        imem_address = '0;
        if (!RESET) begin
            INSTRUCTION  = data[pc_idx][{PC[3:2], 5'b0} +: 32];
            BUSYWAIT     = (state == IDLE) ? !hit : 1'b1;
            imem_read    = read_q;
            imem_address = miss_addr;
        end
    end

endmodule
